fix_ingress_arbiter: RTL
========================

Name: fix_ingress_arbiter

Overview:
- Shares one fix_parser instance between N_REQ FIX byte-stream sources (sessions).
- Grants are whole-message and round-robin.
- The arbiter feeds the parser one byte per cycle and holds the grant until the parser reports msg_complete. It then updates the priority and counts the message.
- It sits between the session receive buffers and the parser. It also owns the parser's reset for error recovery.

Parameters:
- N_REQ, 4, number of requesting sessions (2..8).
- ID_W, 2, width of grant_id; must equal clog2(N_REQ).
- TIMEOUT_CYC, 1024, stall/drain cycles before forced recovery (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_valid  in  N_REQ  per-session byte valid
- s_data  in  8*N_REQ  per-session byte; session i occupies bits [8i+7:8i]
- s_last  in  N_REQ  marks the final byte of a message (checksum-field SOH)
- s_ready  out  N_REQ  per-session accept
- p_data  out  8  byte to parser data_in
- p_valid  out  1  to parser valid_in
- p_msg_complete  in  1  from parser msg_complete
- p_rst  out  1  parser reset, OR'd with the system rst at the parser
- grant_id  out  ID_W  currently or last granted session
- busy  out  1  high in any state other than IDLE
- msg_cnt  out  16  completed messages; wraps at 65535 to 0
- err_proto  out  1  one-cycle pulse: p_msg_complete seen while still streaming
- err_timeout  out  1  one-cycle pulse: timeout recovery (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = N_REQ-1, so session 0 wins first.
- States:
  - IDLE: request vector = s_valid. If non-zero, grant the first set bit searching upward from ptr+1 (mod N_REQ); latch grant_id; go STREAM. Arbitration costs one cycle.
  - STREAM: s_ready[i] = (state==STREAM) && (grant_id==i). A byte is accepted when s_valid[g] & s_ready[g].
    - On accept, register p_data <= s_data[g] and p_valid <= 1 (one-cycle latency). Otherwise p_valid <= 0 and p_data <= 8'h00.
    - Accepted byte with s_last=1 -> DRAIN.
    - p_msg_complete=1 in STREAM -> err_proto pulse, p_rst for 2 cycles, then DISCARD.
  - DRAIN: s_ready low; p_valid drops the cycle after the last byte. Wait for p_msg_complete; the parser asserts it 2 cycles after the last byte is presented. On p_msg_complete: ptr <= grant_id, msg_cnt++, go IDLE.
  - DISCARD: s_ready[g] high; accepted bytes are dropped (p_valid=0). An accepted byte with s_last -> IDLE with ptr <= grant_id and no msg_cnt increment.
- Simultaneous events:
  - p_msg_complete in the same cycle as an s_last accept in STREAM: counts as a good completion (msg_cnt++, IDLE).
  - p_msg_complete in IDLE or DISCARD is ignored.
- The grant never changes mid-message. Sessions that drop s_valid mid-message simply stall STREAM.
- Mid-operation reset: immediate return to IDLE; all counters clear; p_rst deasserts.

Optional Feature:
- Macro FIX_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit stall counter increments each STREAM cycle with no accept and each DRAIN cycle. It clears on accept and on state change.
  - Reaching TIMEOUT_CYC triggers:
    - an err_timeout pulse;
    - p_rst high for 2 cycles;
    - then DISCARD if s_last has not been accepted, else IDLE (ptr <= grant_id).
- Without the macro:
  - no counter is built;
  - err_timeout is tied 0;
  - STREAM and DRAIN wait indefinitely.

Decomposition:
- Package fix_pkg holds:
  - state encoding localparams ARB_IDLE/ARB_STREAM/ARB_DRAIN/ARB_DISCARD/ARB_FLUSH (3-bit);
  - the FIX_SOH = 8'h01 constant;
  - the MSG_CNT_W = 16 constant.
- One sub-module, fix_rr_picker: combinational round-robin search over the request vector given ptr. It returns the grant index and an any_req flag.

Test Plan:
- Single session 0 sends "8=FIX.4.2|9=5|35=D|10=123|" (|=SOH), s_last on the final SOH -> p_data bytes appear 1 cycle after accept, in order; msg_complete accepted in DRAIN; msg_cnt=1; grant_id=0; busy low afterwards.
- Sessions 0,1,2 all holding s_valid from reset, 2 messages each -> grant order 0,1,2,0,1,2; no byte interleaving on p_data; msg_cnt=6.
- Session 1 drops s_valid for 10 cycles mid-message -> p_valid=0 and p_data=8'h00 during the gap; grant stays 1; message still completes.
- p_msg_complete forced high mid-STREAM -> err_proto pulse; p_rst high exactly 2 cycles; remaining bytes through s_last are consumed with p_valid=0; msg_cnt unchanged; next session granted.
- FIX_ARB_TIMEOUT_EN with TIMEOUT_CYC=16: parser held so msg_complete never arrives after s_last -> err_timeout at DRAIN cycle 16; 2-cycle p_rst; back to IDLE; msg_cnt unchanged.
- rst asserted asynchronously during STREAM -> all outputs 0 immediately; the next grant goes to session 0.

Source files
------------

// File: rtl/fix_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fix_pkg
//  Purpose  : Shared types and constants for the FIX ingress arbiter slice.
//             Holds the arbiter state encoding, the FIX field separator and
//             the completed-message counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package fix_pkg;

    // Arbiter state encoding (3-bit)
    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_STREAM  = 3'd1,
        ARB_DRAIN   = 3'd2,
        ARB_DISCARD = 3'd3,
        ARB_FLUSH   = 3'd4
    } arb_state_e;

    // FIX field separator (SOH)
    localparam logic [7:0] FIX_SOH   = 8'h01;

    // Width of the completed-message counter
    localparam int         MSG_CNT_W = 16;

endpackage : fix_pkg
`default_nettype wire

// File: rtl/fix_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : fix_rr_picker
//  Purpose  : Combinational round-robin search. Returns the first set bit of
//             req searching upward from ptr+1 (mod N_REQ).
//  Ports    : req     - request vector
//             ptr     - index of the last served requester
//             grant   - winning index (0 when no request)
//             any_req - at least one request is present
//  Revision : 1.0 - initial release
// ============================================================================
module fix_rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any_req
);

    always_comb begin
        int w_idx;
        w_idx   = 0;
        grant   = '0;
        any_req = |req;
        // Walk from the farthest candidate to the nearest so that the
        // nearest requester after ptr overwrites all others.
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(ptr) + k) % N_REQ;
            if (req[w_idx]) begin
                grant = ID_W'(w_idx);
            end
        end
    end

endmodule : fix_rr_picker
`default_nettype wire

// File: rtl/fix_ingress_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fix_ingress_arbiter
//  Purpose  : Shares one FIX parser between N_REQ session byte streams.
//             Whole-message round-robin grants; one byte per cycle to the
//             parser; grant is held until the parser reports completion.
//             Owns the parser reset for protocol-error / stall recovery.
//  Config   : define FIX_ARB_TIMEOUT_EN to build the stall/drain timeout.
//  Ports    : clk, rst            - clock, async active-high reset
//             s_valid/s_data/s_last/s_ready - per-session byte streams
//             p_data/p_valid      - byte stream to the parser
//             p_msg_complete      - parser completion strobe
//             p_rst               - parser reset (2-cycle recovery pulse)
//             grant_id, busy      - current/last grant, non-IDLE indicator
//             msg_cnt             - completed message count (wraps)
//             err_proto           - completion seen while still streaming
//             err_timeout         - timeout recovery pulse
//  Revision : 1.0 - initial release
// ============================================================================
module fix_ingress_arbiter
    import fix_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      s_valid,
    input  logic [8*N_REQ-1:0]    s_data,
    input  logic [N_REQ-1:0]      s_last,
    output logic [N_REQ-1:0]      s_ready,
    output logic [7:0]            p_data,
    output logic                  p_valid,
    input  logic                  p_msg_complete,
    output logic                  p_rst,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic [MSG_CNT_W-1:0]  msg_cnt,
    output logic                  err_proto,
    output logic                  err_timeout
);

    arb_state_e             r_state, w_state_nxt;
    logic [ID_W-1:0]        r_grant, w_grant_nxt;
    logic [ID_W-1:0]        r_ptr,   w_ptr_nxt;
    logic [MSG_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [7:0]             r_p_data, w_p_data_nxt;
    logic                   r_p_valid, w_p_valid_nxt;
    logic                   r_err_proto, w_err_proto_nxt;
    logic                   r_err_to, w_err_to_nxt;
    logic                   r_p_rst;
    logic                   r_flush_cnt, w_flush_cnt_nxt;
    logic                   r_flush_to_idle, w_flush_to_idle_nxt;

    logic [ID_W-1:0]        w_pick;
    logic                   w_any_req;
    logic                   w_sel_valid;
    logic [7:0]             w_sel_data;
    logic                   w_sel_last;
    logic                   w_ready_state;
    logic                   w_accept;
    logic                   w_timeout;

    fix_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req     (s_valid),
        .ptr     (r_ptr),
        .grant   (w_pick),
        .any_req (w_any_req)
    );

    // Granted session's stream
    assign w_sel_valid   = s_valid[r_grant];
    assign w_sel_data    = s_data[{r_grant, 3'b000} +: 8];
    assign w_sel_last    = s_last[r_grant];
    assign w_ready_state = (r_state == ARB_STREAM) || (r_state == ARB_DISCARD);
    assign w_accept      = w_ready_state && w_sel_valid;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_ready
            assign s_ready[i] = w_ready_state && (r_grant == ID_W'(i));
        end
    endgenerate

`ifdef FIX_ARB_TIMEOUT_EN
    logic [15:0] r_stall;
    logic        w_stall_cyc;

    assign w_stall_cyc = ((r_state == ARB_STREAM) && !w_accept) ||
                         (r_state == ARB_DRAIN);
    // Fires on the TIMEOUT_CYC-th consecutive stalled cycle
    assign w_timeout   = w_stall_cyc && (r_stall == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((w_state_nxt != r_state) || !w_stall_cyc) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + 16'd1;
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign w_timeout            = 1'b0;
`endif

    // Next-state and datapath decode
    always_comb begin
        w_state_nxt         = r_state;
        w_grant_nxt         = r_grant;
        w_ptr_nxt           = r_ptr;
        w_cnt_nxt           = r_cnt;
        w_p_data_nxt        = 8'h00;
        w_p_valid_nxt       = 1'b0;
        w_err_proto_nxt     = 1'b0;
        w_err_to_nxt        = 1'b0;
        w_flush_cnt_nxt     = r_flush_cnt;
        w_flush_to_idle_nxt = r_flush_to_idle;

        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ARB_STREAM;
                end
            end

            ARB_STREAM: begin
                if (w_accept && w_sel_last) begin
                    w_p_data_nxt  = w_sel_data;
                    w_p_valid_nxt = 1'b1;
                    // Completion coinciding with the last byte is a good message
                    if (p_msg_complete) begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_ptr_nxt   = r_grant;
                        w_state_nxt = ARB_IDLE;
                    end else begin
                        w_state_nxt = ARB_DRAIN;
                    end
                end else if (p_msg_complete) begin
                    // Parser finished early: the byte accepted now (if any)
                    // is dropped along with the rest of the message.
                    w_err_proto_nxt     = 1'b1;
                    w_flush_cnt_nxt     = 1'b0;
                    w_flush_to_idle_nxt = 1'b0;
                    w_state_nxt         = ARB_FLUSH;
                end else if (w_accept) begin
                    w_p_data_nxt  = w_sel_data;
                    w_p_valid_nxt = 1'b1;
                end else if (w_timeout) begin
                    w_err_to_nxt        = 1'b1;
                    w_flush_cnt_nxt     = 1'b0;
                    w_flush_to_idle_nxt = 1'b0;
                    w_state_nxt         = ARB_FLUSH;
                end
            end

            ARB_DRAIN: begin
                if (p_msg_complete) begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_ptr_nxt   = r_grant;
                    w_state_nxt = ARB_IDLE;
                end else if (w_timeout) begin
                    w_err_to_nxt        = 1'b1;
                    w_flush_cnt_nxt     = 1'b0;
                    w_flush_to_idle_nxt = 1'b1;
                    w_state_nxt         = ARB_FLUSH;
                end
            end

            ARB_DISCARD: begin
                if (w_accept && w_sel_last) begin
                    w_ptr_nxt   = r_grant;
                    w_state_nxt = ARB_IDLE;
                end
            end

            ARB_FLUSH: begin
                // Two cycles of parser reset, then resume
                if (r_flush_cnt) begin
                    if (r_flush_to_idle) begin
                        w_ptr_nxt   = r_grant;
                        w_state_nxt = ARB_IDLE;
                    end else begin
                        w_state_nxt = ARB_DISCARD;
                    end
                end else begin
                    w_flush_cnt_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ARB_IDLE;
            r_grant         <= '0;
            r_ptr           <= ID_W'(N_REQ - 1);
            r_cnt           <= '0;
            r_p_data        <= 8'h00;
            r_p_valid       <= 1'b0;
            r_err_proto     <= 1'b0;
            r_err_to        <= 1'b0;
            r_p_rst         <= 1'b0;
            r_flush_cnt     <= 1'b0;
            r_flush_to_idle <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_grant         <= w_grant_nxt;
            r_ptr           <= w_ptr_nxt;
            r_cnt           <= w_cnt_nxt;
            r_p_data        <= w_p_data_nxt;
            r_p_valid       <= w_p_valid_nxt;
            r_err_proto     <= w_err_proto_nxt;
            r_err_to        <= w_err_to_nxt;
            // Registered so the parser reset is glitch-free
            r_p_rst         <= (w_state_nxt == ARB_FLUSH);
            r_flush_cnt     <= w_flush_cnt_nxt;
            r_flush_to_idle <= w_flush_to_idle_nxt;
        end
    end

    assign p_data    = r_p_data;
    assign p_valid   = r_p_valid;
    assign p_rst     = r_p_rst;
    assign grant_id  = r_grant;
    assign busy      = (r_state != ARB_IDLE);
    assign msg_cnt   = r_cnt;
    assign err_proto = r_err_proto;

`ifdef FIX_ARB_TIMEOUT_EN
    assign err_timeout = r_err_to;
`else
    logic w_unused_err_to;
    assign w_unused_err_to = r_err_to;
    assign err_timeout     = 1'b0;
`endif

endmodule : fix_ingress_arbiter
`default_nettype wire
